iot_event_tx: RTL

//  Transmit side of the active-device change/on_off interface. Watches a vector of

---
 rtl/iot_event_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/iot_event_tx.sv
// Transmit side of the active-device change/on_off interface: queues per-device
// connect/disconnect events and issues them round-robin as single-cycle change pulses.
module iot_event_tx #(
  parameter int N_DEV = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = 8,
  localparam int ID_W = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  input  logic             enable,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             busy,
  output logic             pending,
  output logic [CNT_W-1:0] active_count,
  output logic             drop_err
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP_S} state_t;

  state_t             state, state_nxt;
  logic [N_DEV-1:0]   dev_q, rise, fall;
  logic [N_DEV-1:0]   pend, pend_dir, pend_nxt, dir_nxt;
  logic [ID_W-1:0]    rr_ptr, sel_nxt;
  logic [3:0]         gap_cnt;
  logic               found, start, emit;
  logic [2*N_DEV-1:0] pend_rot;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + CNT_W'(1);
    else    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic sat_hit(input logic [CNT_W-1:0] c, input logic up);
    return up ? (&c) : (c == '0);
  endfunction

  assign rise    = dev_active & ~dev_q;
  assign fall    = ~dev_active & dev_q;
  assign emit    = (state == EMIT);
  assign busy    = (state != IDLE);
  assign pending = |pend;

  // Round-robin pick: rotate pend so rr_ptr lands at bit 0, take the lowest set bit.
  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    sel_nxt  = '0;
    pend_rot = {pend, pend} >> rr_ptr;
    for (int k = 0; k < N_DEV; k++) begin
      if (!found && pend_rot[k]) begin
        found = 1'b1;
        j     = k + int'(rr_ptr);
        if (j >= N_DEV) j = j - N_DEV;
        sel_nxt = ID_W'(j);
      end
    end
  end

  // The device being emitted clears first, so an edge seen during its pulse re-queues it.
  always_comb begin
    logic ev;
    ev       = 1'b0;
    pend_nxt = pend;
    dir_nxt  = pend_dir;
    for (int i = 0; i < N_DEV; i++) begin
      ev = rise[i] | fall[i];
      if (emit && dev_id == ID_W'(i)) begin
        pend_nxt[i] = ev;
        if (ev) dir_nxt[i] = rise[i];
      end else if (ev) begin
        if (!pend[i]) begin
          pend_nxt[i] = 1'b1;
          dir_nxt[i]  = rise[i];
        end else if (pend_dir[i] != rise[i]) begin
          pend_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_nxt = EMIT;
          start     = 1'b1;
        end
      end
      EMIT:    state_nxt = (GAP > 0) ? GAP_S : IDLE;
      GAP_S:   if (gap_cnt == 4'(GAP - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dev_q        <= '0;
      pend         <= '0;
      pend_dir     <= '0;
      rr_ptr       <= '0;
      gap_cnt      <= '0;
      active_count <= '0;
      drop_err     <= 1'b0;
      change       <= 1'b0;
      on_off       <= 1'b0;
      dev_id       <= '0;
    end else begin
      dev_q    <= dev_active;
      pend     <= pend_nxt;
      pend_dir <= dir_nxt;
      change   <= start;
      if (start) begin
        on_off <= pend_dir[sel_nxt];
        dev_id <= sel_nxt;
      end
      if (emit) begin
        rr_ptr       <= (dev_id == ID_W'(N_DEV - 1)) ? '0 : dev_id + ID_W'(1);
        active_count <= sat_step(active_count, on_off);
        if (sat_hit(active_count, on_off)) drop_err <= 1'b1;
        gap_cnt      <= '0;
      end else if (state == GAP_S) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

endmodule
